run_ctrl: RTL and testbench

Run-control sequencer for the single-cycle core. It owns the PC commit enable and decides when the core runs, single-steps, halts or latches an error, based on host commands, the core's exception vector and a PC breakpoint comparator. It sits between the top-level monitor and the `PC`/`CPU` pair, replacing the bare `state == NORMAL` write gate. It also keeps cycle and retired-instruction counters for the display path.

---
 rtl/run_ctrl.sv | 152 +++++++++++++++
 tb/tb_run_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// Run-control sequencer: gates PC commit, sequences RUN/STEP/HALT/ERROR from host
// commands, core exceptions and a PC breakpoint, and keeps cycle/instret counters.
module run_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  input  logic [1:0]            cmd_i,
  output logic                  cmd_ready_o,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [5:0]            exc_i,
  input  logic                  bp_en_i,
  input  logic [DATA_WIDTH-1:0] bp_addr_i,
  output logic                  pc_we_o,
  output logic [2:0]            state_o,
  output logic [3:0]            halt_cause_o,
  output logic [CNT_WIDTH-1:0]  cycle_cnt_o,
  output logic [CNT_WIDTH-1:0]  instret_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_HALT  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  localparam logic [1:0] CMD_RUN   = 2'd0;
  localparam logic [1:0] CMD_STEP  = 2'd1;
  localparam logic [1:0] CMD_HALT  = 2'd2;
  localparam logic [1:0] CMD_CLEAR = 2'd3;

  localparam logic [3:0] CAUSE_ECALL  = 4'd4;
  localparam logic [3:0] CAUSE_EBREAK = 4'd5;
  localparam logic [3:0] CAUSE_BP     = 4'd6;
  localparam logic [3:0] CAUSE_HOST   = 4'd7;
  localparam logic [3:0] CAUSE_STEP   = 4'd8;
  localparam logic [3:0] CAUSE_NONE   = 4'hF;

  state_t               r_state, w_state_nxt, w_stop_state;
  logic [3:0]           r_cause, w_cause_nxt, w_stop_cause, w_anom_idx;
  logic                 r_skip;
  logic [CNT_WIDTH-1:0] r_cycle, r_instret;

  logic w_active, w_anom, w_bp_hit, w_ecall, w_ebreak, w_stop;
  logic w_cmd_acc, w_clr, w_enter;

  assign w_active  = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign w_anom    = |exc_i[3:0];
  assign w_bp_hit  = bp_en_i && (pc_i == bp_addr_i) && !r_skip;
  assign w_ecall   = exc_i[4] && !r_skip;
  assign w_ebreak  = exc_i[5] && !r_skip;
  assign w_stop    = w_anom || w_ecall || w_ebreak || w_bp_hit;

  assign cmd_ready_o = !rst_i && (r_state != ST_STEP);
  assign pc_we_o     = !rst_i && w_active && !w_stop;
  assign w_cmd_acc   = cmd_valid_i && cmd_ready_o;

  // Lowest set anomaly bit wins when several fire together.
  always_comb begin
    w_anom_idx = 4'd0;
    if      (exc_i[0]) w_anom_idx = 4'd0;
    else if (exc_i[1]) w_anom_idx = 4'd1;
    else if (exc_i[2]) w_anom_idx = 4'd2;
    else if (exc_i[3]) w_anom_idx = 4'd3;
  end

  always_comb begin
    w_stop_state = ST_HALT;
    w_stop_cause = CAUSE_BP;
    if (w_anom) begin
      w_stop_state = ST_ERROR;
      w_stop_cause = w_anom_idx;
    end else if (w_ebreak) begin
      w_stop_cause = CAUSE_EBREAK;
    end else if (w_ecall) begin
      w_stop_cause = CAUSE_ECALL;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    w_clr       = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (w_cmd_acc && cmd_i == CMD_RUN)       w_state_nxt = ST_RUN;
        else if (w_cmd_acc && cmd_i == CMD_STEP) w_state_nxt = ST_STEP;
      end
      ST_RUN: begin
        if (w_stop) begin
          w_state_nxt = w_stop_state;
          w_cause_nxt = w_stop_cause;
        end else if (w_cmd_acc && cmd_i == CMD_HALT) begin
          w_state_nxt = ST_HALT;
          w_cause_nxt = CAUSE_HOST;
        end
      end
      ST_STEP: begin
        // Skip is always set here, so only an anomaly can stop a step.
        if (w_stop) begin
          w_state_nxt = w_stop_state;
          w_cause_nxt = w_stop_cause;
        end else begin
          w_state_nxt = ST_HALT;
          w_cause_nxt = CAUSE_STEP;
        end
      end
      ST_ERROR: begin
        if (w_cmd_acc && cmd_i == CMD_CLEAR) begin
          w_state_nxt = ST_IDLE;
          w_cause_nxt = CAUSE_NONE;
          w_clr       = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_enter = ((w_state_nxt == ST_RUN) || (w_state_nxt == ST_STEP)) &&
                   (w_state_nxt != r_state);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_cause   <= CAUSE_NONE;
      r_skip    <= 1'b0;
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cause <= w_cause_nxt;
      r_skip  <= w_enter;
      if (w_clr) begin
        r_cycle   <= '0;
        r_instret <= '0;
      end else begin
        r_cycle   <= r_cycle + CNT_WIDTH'(w_active);
        r_instret <= r_instret + CNT_WIDTH'(pc_we_o);
      end
    end
  end

  assign state_o      = r_state;
  assign halt_cause_o = r_cause;
  assign cycle_cnt_o  = r_cycle;
  assign instret_o    = r_instret;

endmodule

// File: tb/tb_run_ctrl.sv
// Vector-table bench for run_ctrl; registered results go through a scoreboard queue.
// A second instance with 4-bit counters shares the stimulus to exercise wrap.
module tb_run_ctrl;

  localparam logic [63:0] PA = 64'h0000_1000;
  localparam logic [63:0] BP = 64'h8000_0010;

  logic        clk = 1'b0;
  logic        rst_i, cmd_valid_i, bp_en_i;
  logic [1:0]  cmd_i;
  logic [5:0]  exc_i;
  logic [63:0] pc_i, bp_addr_i;

  logic        rdy, we, rdy4, we4;
  logic [2:0]  st, st4;
  logic [3:0]  cause, cause4;
  logic [31:0] cyc, ins;
  logic [3:0]  cyc4, ins4;

  always #5 clk = ~clk;

  run_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_i(cmd_i),
    .cmd_ready_o(rdy), .pc_i(pc_i), .exc_i(exc_i), .bp_en_i(bp_en_i),
    .bp_addr_i(bp_addr_i), .pc_we_o(we), .state_o(st), .halt_cause_o(cause),
    .cycle_cnt_o(cyc), .instret_o(ins)
  );

  run_ctrl #(.DATA_WIDTH(64), .CNT_WIDTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_i(cmd_i),
    .cmd_ready_o(rdy4), .pc_i(pc_i), .exc_i(exc_i), .bp_en_i(bp_en_i),
    .bp_addr_i(bp_addr_i), .pc_we_o(we4), .state_o(st4), .halt_cause_o(cause4),
    .cycle_cnt_o(cyc4), .instret_o(ins4)
  );

  typedef struct {
    logic        rst, cv;
    logic [1:0]  cmd;
    logic [5:0]  exc;
    logic [63:0] pc;
    logic        bp;
    logic        we, rdy;
    logic [2:0]  st;
    logic [3:0]  cause;
  } vec_t;

  typedef struct {
    logic [2:0]  st;
    logic [3:0]  cause;
    int unsigned cyc, ins;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [2:0]  m_st = 3'd0;
  int unsigned m_cyc = 0, m_ins = 0;

  function automatic vec_t mk(logic r, logic cv, logic [1:0] cmd, logic [5:0] exc,
                              logic [63:0] pc, logic bp, logic w, logic rd,
                              logic [2:0] s, logic [3:0] c);
    vec_t v;
    v.rst = r; v.cv = cv; v.cmd = cmd; v.exc = exc; v.pc = pc; v.bp = bp;
    v.we = w; v.rdy = rd; v.st = s; v.cause = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle: combinational outputs checked before the edge,
  // registered outputs popped from the scoreboard after it.
  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst_i = v.rst; cmd_valid_i = v.cv; cmd_i = v.cmd; exc_i = v.exc;
    pc_i = v.pc; bp_en_i = v.bp;
    #1;
    chk("pc_we", {63'd0, we}, {63'd0, v.we});
    chk("cmd_ready", {63'd0, rdy}, {63'd0, v.rdy});
    chk("pc_we4", {63'd0, we4}, {63'd0, v.we});
    if (v.rst || (v.cv && v.cmd == 2'd3 && m_st == 3'd4)) begin
      m_cyc = 0; m_ins = 0;
    end else begin
      if (m_st == 3'd1 || m_st == 3'd2) m_cyc++;
      if (v.we) m_ins++;
    end
    m_st = v.st;
    e.st = v.st; e.cause = v.cause; e.cyc = m_cyc; e.ins = m_ins;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk("state", {61'd0, st}, {61'd0, e.st});
      chk("cause", {60'd0, cause}, {60'd0, e.cause});
      chk("cycle_cnt", {32'd0, cyc}, {32'd0, e.cyc});
      chk("instret", {32'd0, ins}, {32'd0, e.ins});
      chk("cycle_cnt4", {60'd0, cyc4}, {60'd0, e.cyc[3:0]});
      chk("instret4", {60'd0, ins4}, {60'd0, e.ins[3:0]});
    end
  endtask

  initial begin
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_i = 2'd0; exc_i = 6'd0;
    pc_i = PA; bp_en_i = 1'b0; bp_addr_i = BP;

    //                 rst cv cmd exc         pc                bp  we rdy st    cause
    vecs.push_back(mk(1, 0, 0, 6'b000000, PA,               0, 0, 0, 3'd0, 4'hF));
    vecs.push_back(mk(0, 1, 0, 6'b000000, PA,               0, 0, 1, 3'd1, 4'hF));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(0, 0, 0, 6'b000000, PA,             0, 1, 1, 3'd1, 4'hF));
    vecs.push_back(mk(0, 1, 2, 6'b000000, PA,               0, 1, 1, 3'd3, 4'd7));
    // breakpoint hit, then resume over it
    vecs.push_back(mk(0, 1, 0, 6'b000000, PA,               0, 0, 1, 3'd1, 4'd7));
    vecs.push_back(mk(0, 0, 0, 6'b000000, 64'h8000_0000,    1, 1, 1, 3'd1, 4'd7));
    vecs.push_back(mk(0, 0, 0, 6'b000000, BP,               1, 0, 1, 3'd3, 4'd6));
    vecs.push_back(mk(0, 1, 0, 6'b000000, BP,               1, 0, 1, 3'd1, 4'd6));
    vecs.push_back(mk(0, 0, 0, 6'b000000, BP,               1, 1, 1, 3'd1, 4'd6));
    vecs.push_back(mk(0, 0, 0, 6'b000000, 64'h8000_0014,    1, 1, 1, 3'd1, 4'd6));
    vecs.push_back(mk(0, 1, 2, 6'b000000, PA,               0, 1, 1, 3'd3, 4'd7));
    // single step with EBREAK masked by skip; command during STEP not ready
    vecs.push_back(mk(0, 1, 1, 6'b000000, PA,               0, 0, 1, 3'd2, 4'd7));
    vecs.push_back(mk(0, 1, 1, 6'b100000, PA,               0, 1, 0, 3'd3, 4'd8));
    vecs.push_back(mk(0, 0, 0, 6'b000000, PA,               0, 0, 1, 3'd3, 4'd8));
    // anomaly beats EBREAK, RUN ignored in ERROR, CLEAR
    vecs.push_back(mk(0, 1, 0, 6'b000000, PA,               0, 0, 1, 3'd1, 4'd8));
    vecs.push_back(mk(0, 0, 0, 6'b100100, PA,               0, 0, 1, 3'd4, 4'd2));
    vecs.push_back(mk(0, 1, 0, 6'b000000, PA,               0, 0, 1, 3'd4, 4'd2));
    vecs.push_back(mk(0, 1, 3, 6'b000000, PA,               0, 0, 1, 3'd0, 4'hF));
    // EBREAK with host HALT same cycle, resume over EBREAK, then ECALL
    vecs.push_back(mk(0, 1, 0, 6'b000000, PA,               0, 0, 1, 3'd1, 4'hF));
    vecs.push_back(mk(0, 0, 0, 6'b000000, PA,               0, 1, 1, 3'd1, 4'hF));
    vecs.push_back(mk(0, 1, 2, 6'b100000, PA,               0, 0, 1, 3'd3, 4'd5));
    vecs.push_back(mk(0, 1, 0, 6'b100000, PA,               0, 0, 1, 3'd1, 4'd5));
    vecs.push_back(mk(0, 0, 0, 6'b100000, PA,               0, 1, 1, 3'd1, 4'd5));
    vecs.push_back(mk(0, 0, 0, 6'b000000, PA,               0, 1, 1, 3'd1, 4'd5));
    vecs.push_back(mk(0, 0, 0, 6'b010000, PA,               0, 0, 1, 3'd3, 4'd4));
    // reset mid-RUN with a pending HALT
    vecs.push_back(mk(0, 1, 0, 6'b000000, PA,               0, 0, 1, 3'd1, 4'd4));
    vecs.push_back(mk(0, 0, 0, 6'b000000, PA,               0, 1, 1, 3'd1, 4'd4));
    vecs.push_back(mk(1, 1, 2, 6'b000000, PA,               0, 0, 0, 3'd0, 4'hF));
    vecs.push_back(mk(0, 0, 0, 6'b000000, PA,               0, 0, 1, 3'd0, 4'hF));
    // anomaly during STEP, lowest set bit reported
    vecs.push_back(mk(0, 1, 1, 6'b000000, PA,               0, 0, 1, 3'd2, 4'hF));
    vecs.push_back(mk(0, 0, 0, 6'b001010, PA,               0, 0, 0, 3'd4, 4'd1));
    vecs.push_back(mk(1, 0, 0, 6'b000000, PA,               0, 0, 0, 3'd0, 4'hF));

    foreach (vecs[i]) apply(vecs[i]);

    // counter wrap: 17 commits on the 4-bit instance
    apply(mk(0, 1, 0, 6'b000000, PA, 0, 0, 1, 3'd1, 4'hF));
    for (int i = 0; i < 17; i++)
      apply(mk(0, 0, 0, 6'b000000, PA, 0, 1, 1, 3'd1, 4'hF));
    chk("instret4_wrap", {60'd0, ins4}, 64'd1);
    chk("instret_full", {32'd0, ins}, 64'd17);
    chk("state4", {61'd0, st4}, 64'd1);
    chk("cause4", {60'd0, cause4}, 64'hF);
    chk("ready4", {63'd0, rdy4}, 64'd1);
    apply(mk(1, 0, 0, 6'b000000, PA, 0, 0, 0, 3'd0, 4'hF));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
